// File: rtl/t_second_if.sv
// t_second_if -- bundles the control inputs and display outputs of the
// seconds stage.
//   master : the driver side (buttons, freeze switch, display consumer)
//   slave  : the seconds stage itself
//   control1    adjust button, active-low, already debounced
//   control0    adjust direction (1 = +1, 0 = -1)
//   disable_sec freeze automatic counting
//   equal60     wrap level to the minute stage
//   count_dis   seconds 0..59
//   blink       colon blink, high in the first half of each second
//   led2/led1   tens/units seven-segment patterns
interface t_second_if;
   logic       control1;
   logic       control0;
   logic       disable_sec;
   logic       equal60;
   logic [5:0] count_dis;
   logic       blink;
   logic [6:0] led2;
   logic [6:0] led1;

   modport master (
      output control1, control0, disable_sec,
      input  equal60, count_dis, blink, led2, led1
   );

   modport slave (
      input  control1, control0, disable_sec,
      output equal60, count_dis, blink, led2, led1
   );
endinterface

// File: rtl/t_second.sv
// t_second -- seconds stage of the digital clock.
// Divides clk50 down to a TICK_HZ strobe, counts seconds 0..59, raises
// equal60 for one full second after each automatic 59->0 wrap, supports
// single-step manual adjust and a freeze input, and drives two 7-segment
// digits plus a colon blink.
// Ports:
//   clk50  system clock
//   reset  synchronous reset, active-low
//   bus    t_second_if.slave (controls in, count/wrap/blink/segments out)
// DIV = CLK_HZ/TICK_HZ must be an even integer >= 4, and 2**PW > DIV.

// Splits a 0..59 value into BCD tens and units digits.
module separate (
   input  logic [5:0] i_val,
   output logic [3:0] o_tens,
   output logic [3:0] o_units
);
   assign o_tens  = 4'(i_val / 6'd10);
   assign o_units = 4'(i_val % 6'd10);
endmodule

// BCD digit to active-high segments {g,f,e,d,c,b,a}; blank when disabled
// or when the digit is not 0..9.
module led7_decoder (
   input  logic       i_en,
   input  logic [3:0] i_bcd,
   output logic [6:0] o_seg
);
   always_comb begin
      o_seg = 7'h00;
      if (i_en) begin
         case (i_bcd)
            4'd0:    o_seg = 7'h3F;
            4'd1:    o_seg = 7'h06;
            4'd2:    o_seg = 7'h5B;
            4'd3:    o_seg = 7'h4F;
            4'd4:    o_seg = 7'h66;
            4'd5:    o_seg = 7'h6D;
            4'd6:    o_seg = 7'h7D;
            4'd7:    o_seg = 7'h07;
            4'd8:    o_seg = 7'h7F;
            4'd9:    o_seg = 7'h6F;
            default: o_seg = 7'h00;
         endcase
      end
   end
endmodule

module t_second #(
   parameter int CLK_HZ  = 50000000,
   parameter int TICK_HZ = 1,
   parameter int PW      = 26
) (
   input  logic         clk50,
   input  logic         reset,
   t_second_if.slave    bus
);
   localparam int            DIV    = CLK_HZ / TICK_HZ;
   localparam logic [PW-1:0] LAST   = PW'(DIV - 1);
   localparam logic [PW-1:0] HALF   = PW'(DIV / 2);

   logic [PW-1:0] r_presc;
   logic [5:0]    r_count;
   logic          r_equal60;
   logic          r_blink;
   logic          r_latch;    // 1 = press already acted on, waiting for release

   logic          w_tick;
   logic          w_press;
   logic          w_release;
   logic [5:0]    w_step;
   logic [3:0]    w_tens;
   logic [3:0]    w_units;

   assign w_tick    = !bus.disable_sec && (r_presc == LAST);
   assign w_press   = !bus.control1 && !r_latch;
   assign w_release =  bus.control1 &&  r_latch;

   // Manual step value, wrapping in both directions within 0..59.
   always_comb begin
      w_step = r_count;
      if (bus.control0) w_step = (r_count == 6'd59) ? 6'd0  : r_count + 6'd1;
      else              w_step = (r_count == 6'd0)  ? 6'd59 : r_count - 6'd1;
   end

   always_ff @(posedge clk50) begin
      if (!reset) begin
         r_presc   <= '0;
         r_count   <= '0;
         r_equal60 <= 1'b0;
         r_blink   <= 1'b0;
         r_latch   <= 1'b0;
      end else begin
         // Held at 0 while frozen so the first tick after release is a
         // full period away.
         if (bus.disable_sec || r_presc == LAST) r_presc <= '0;
         else                                    r_presc <= r_presc + 1'b1;

         r_blink <= !bus.disable_sec && (r_presc < HALF);

         // Freezing drops the wrap level; ticks cannot fire while frozen,
         // so this never races with the set below.
         if (bus.disable_sec) r_equal60 <= 1'b0;

         // Button events own the cycle: a coincident tick is discarded.
         if (w_press) begin
            r_latch <= 1'b1;
            r_count <= w_step;
         end else if (w_release) begin
            r_latch <= 1'b0;
         end else if (w_tick) begin
            if (r_count == 6'd59) begin
               r_count   <= 6'd0;
               r_equal60 <= 1'b1;
            end else begin
               r_count   <= r_count + 6'd1;
               r_equal60 <= 1'b0;
            end
         end
      end
   end

   separate u_sep (
      .i_val   (r_count),
      .o_tens  (w_tens),
      .o_units (w_units)
   );

   led7_decoder u_dec_tens (
      .i_en  (1'b1),
      .i_bcd (w_tens),
      .o_seg (bus.led2)
   );

   led7_decoder u_dec_units (
      .i_en  (1'b1),
      .i_bcd (w_units),
      .o_seg (bus.led1)
   );

   assign bus.count_dis = r_count;
   assign bus.equal60   = r_equal60;
   assign bus.blink     = r_blink;
endmodule

// File: tb/tb_t_second.sv
module tb_t_second;
   localparam int DIV = 10;

   logic clk50 = 1'b0;
   logic reset;
   always #5 clk50 = ~clk50;

   t_second_if bus ();

   t_second #(.CLK_HZ(10), .TICK_HZ(1), .PW(26)) dut (
      .clk50 (clk50),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      int cnt;
      bit eq;
      bit bl;
      logic [6:0] l2;
      logic [6:0] l1;
   } exp_t;

   typedef enum int {K_RUN, K_STEP} kind_t;

   typedef struct {
      string nm;
      kind_t kind;
      int    n;      // cycles (K_RUN) or press/release pairs (K_STEP)
      bit    rst_n;
      bit    c1;
      bit    c0;
      bit    dis;
      int    e_cnt;
      int    e_eq;
      int    e_bl;   // -1 = not checked
   } vec_t;

   exp_t sb[$];
   vec_t tbl[$];
   int   n_vec = 0;
   int   n_err = 0;

   // Reference state derived from the behavioural description.
   int m_presc, m_cnt;
   bit m_eq, m_bl, m_latch;

   function automatic logic [6:0] seg(input int d);
      logic [6:0] s;
      case (d)
         0: s = 7'h3F; 1: s = 7'h06; 2: s = 7'h5B; 3: s = 7'h4F; 4: s = 7'h66;
         5: s = 7'h6D; 6: s = 7'h7D; 7: s = 7'h07; 8: s = 7'h7F; 9: s = 7'h6F;
         default: s = 7'h00;
      endcase
      return s;
   endfunction

   task automatic model(input bit rst_n, input bit c1, input bit c0, input bit dis);
      bit tick, nb;
      exp_t e;
      if (!rst_n) begin
         m_presc = 0; m_cnt = 0; m_eq = 0; m_bl = 0; m_latch = 0;
      end else begin
         tick = !dis && (m_presc == DIV - 1);
         nb   = !dis && (m_presc < DIV / 2);
         m_presc = (dis || m_presc == DIV - 1) ? 0 : m_presc + 1;
         if (dis) m_eq = 0;
         if (!c1 && !m_latch) begin
            m_latch = 1;
            if (c0) m_cnt = (m_cnt == 59) ? 0 : m_cnt + 1;
            else    m_cnt = (m_cnt == 0) ? 59 : m_cnt - 1;
         end else if (c1 && m_latch) begin
            m_latch = 0;
         end else if (tick) begin
            if (m_cnt == 59) begin m_cnt = 0; m_eq = 1; end
            else begin m_cnt = m_cnt + 1; m_eq = 0; end
         end
         m_bl = nb;
      end
      e.cnt = m_cnt; e.eq = m_eq; e.bl = m_bl;
      e.l2 = seg(m_cnt / 10); e.l1 = seg(m_cnt % 10);
      sb.push_back(e);
   endtask

   // One clock: drive, predict, clock, then compare the popped prediction.
   task automatic cycle(input bit rst_n, input bit c1, input bit c0, input bit dis);
      exp_t e;
      reset = rst_n; bus.control1 = c1; bus.control0 = c0; bus.disable_sec = dis;
      model(rst_n, c1, c0, dis);
      @(posedge clk50);
      #1;
      e = sb.pop_front();
      n_vec++;
      if (bus.count_dis !== 6'(e.cnt) || bus.equal60 !== e.eq || bus.blink !== e.bl ||
          bus.led2 !== e.l2 || bus.led1 !== e.l1) begin
         n_err++;
         $display("FAIL sb t=%0t got cnt=%0d eq=%b bl=%b l2=%h l1=%h want cnt=%0d eq=%b bl=%b l2=%h l1=%h",
                  $time, bus.count_dis, bus.equal60, bus.blink, bus.led2, bus.led1,
                  e.cnt, e.eq, e.bl, e.l2, e.l1);
      end
   endtask

   task automatic step(input bit c0, input bit dis);
      cycle(1'b1, 1'b0, c0, dis);
      cycle(1'b1, 1'b1, c0, dis);
   endtask

   task automatic check(input string nm, input int cnt, input int eq, input int bl);
      n_vec++;
      if (bus.count_dis !== 6'(cnt) || bus.equal60 !== 1'(eq) ||
          (bl >= 0 && bus.blink !== 1'(bl))) begin
         n_err++;
         $display("FAIL %s got cnt=%0d eq=%b bl=%b want cnt=%0d eq=%0d bl=%0d",
                  nm, bus.count_dis, bus.equal60, bus.blink, cnt, eq, bl);
      end
   endtask

   function automatic vec_t row(input string nm, input kind_t k, input int n,
                                input bit r, input bit c1, input bit c0, input bit dis,
                                input int ec, input int ee, input int eb);
      vec_t v;
      v.nm = nm; v.kind = k; v.n = n; v.rst_n = r; v.c1 = c1; v.c0 = c0; v.dis = dis;
      v.e_cnt = ec; v.e_eq = ee; v.e_bl = eb;
      return v;
   endfunction

   initial begin
      reset = 1'b0; bus.control1 = 1'b1; bus.control0 = 1'b1; bus.disable_sec = 1'b0;

      //                 name               kind   n   rst c1 c0 dis  cnt eq bl
      tbl.push_back(row("reset",            K_RUN,  2,  0, 1, 1, 0,   0, 0, 0));
      tbl.push_back(row("blink_hi",         K_RUN,  3,  1, 1, 1, 0,   0, 0, 1));
      tbl.push_back(row("blink_lo",         K_RUN,  6,  1, 1, 1, 0,   0, 0, 0));
      tbl.push_back(row("first_tick",       K_RUN,  1,  1, 1, 1, 0,   1, 0, 0));
      tbl.push_back(row("second_start",     K_RUN,  1,  1, 1, 1, 0,   1, 0, 1));
      tbl.push_back(row("reach_59",         K_RUN,579,  1, 1, 1, 0,  59, 0, 0));
      tbl.push_back(row("pre_wrap",         K_RUN,  9,  1, 1, 1, 0,  59, 0, 0));
      tbl.push_back(row("wrap",             K_RUN,  1,  1, 1, 1, 0,   0, 1, 0));
      tbl.push_back(row("eq_hold",          K_RUN,  9,  1, 1, 1, 0,   0, 1, 0));
      tbl.push_back(row("eq_fall",          K_RUN,  1,  1, 1, 1, 0,   1, 0, 0));
      tbl.push_back(row("step_dn",          K_STEP, 1,  1, 1, 0, 1,   0, 0, 0));
      tbl.push_back(row("hold_dn_wrap",     K_RUN, 30,  1, 0, 0, 1,  59, 0, 0));
      tbl.push_back(row("release",          K_RUN,  1,  1, 1, 0, 1,  59, 0, 0));
      tbl.push_back(row("up_wrap",          K_RUN,  3,  1, 0, 1, 1,   0, 0, 0));
      tbl.push_back(row("release2",         K_RUN,  1,  1, 1, 1, 1,   0, 0, 0));
      tbl.push_back(row("step_to_17",       K_STEP,17,  1, 1, 1, 1,  17, 0, 0));
      tbl.push_back(row("freeze",           K_RUN,100,  1, 1, 1, 1,  17, 0, 0));
      tbl.push_back(row("resume_wait",      K_RUN,  9,  1, 1, 1, 0,  17, 0, 0));
      tbl.push_back(row("resume_tick",      K_RUN,  1,  1, 1, 1, 0,  18, 0, 0));
      tbl.push_back(row("step_to_5",        K_STEP,13,  1, 1, 0, 1,   5, 0, 0));
      tbl.push_back(row("pre_coincide",     K_RUN,  9,  1, 1, 1, 0,   5, 0, -1));
      tbl.push_back(row("press_on_tick",    K_RUN,  1,  1, 0, 1, 0,   6, 0, 0));
      tbl.push_back(row("release_nt",       K_RUN,  1,  1, 1, 1, 0,   6, 0, -1));
      tbl.push_back(row("no_double",        K_RUN,  8,  1, 1, 1, 0,   6, 0, -1));
      tbl.push_back(row("next_tick",        K_RUN,  1,  1, 1, 1, 0,   7, 0, 0));
      tbl.push_back(row("step_to_59",       K_STEP, 8,  1, 1, 0, 1,  59, 0, 0));
      tbl.push_back(row("wrap2",            K_RUN, 10,  1, 1, 1, 0,   0, 1, 0));
      tbl.push_back(row("mid_second",       K_RUN,  4,  1, 1, 1, 0,   0, 1, 1));
      tbl.push_back(row("mid_reset",        K_RUN,  1,  0, 1, 1, 0,   0, 0, 0));
      tbl.push_back(row("post_reset_wait",  K_RUN,  9,  1, 1, 1, 0,   0, 0, 0));
      tbl.push_back(row("post_reset_tick",  K_RUN,  1,  1, 1, 1, 0,   1, 0, 0));
      tbl.push_back(row("step_to_59b",      K_STEP, 2,  1, 1, 0, 1,  59, 0, 0));
      tbl.push_back(row("wrap3",            K_RUN, 10,  1, 1, 1, 0,   0, 1, 0));
      tbl.push_back(row("dis_clears_eq",    K_RUN,  1,  1, 1, 1, 1,   0, 0, 0));

      foreach (tbl[i]) begin
         if (tbl[i].kind == K_STEP)
            for (int k = 0; k < tbl[i].n; k++) step(tbl[i].c0, tbl[i].dis);
         else
            for (int k = 0; k < tbl[i].n; k++)
               cycle(tbl[i].rst_n, tbl[i].c1, tbl[i].c0, tbl[i].dis);
         check(tbl[i].nm, tbl[i].e_cnt, tbl[i].e_eq, tbl[i].e_bl);
      end

      // Release landing on the falling tick: equal60 survives until the
      // next applied tick.
      step(1'b0, 1'b1);                          // 0 -> 59
      repeat (10) cycle(1'b1, 1'b1, 1'b1, 1'b0);
      check("wrap4", 0, 1, 0);
      repeat (8) cycle(1'b1, 1'b1, 1'b1, 1'b0);  // prescaler at 8
      cycle(1'b1, 1'b0, 1'b1, 1'b0);             // press: 0 -> 1
      check("press_keeps_eq", 1, 1, -1);
      cycle(1'b1, 1'b1, 1'b1, 1'b0);             // release eats the tick
      check("release_eats_tick", 1, 1, -1);
      repeat (9) cycle(1'b1, 1'b1, 1'b1, 1'b0);
      check("eq_still_high", 1, 1, -1);
      cycle(1'b1, 1'b1, 1'b1, 1'b0);
      check("late_eq_fall", 2, 0, -1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
